// File: rtl/xor_lane_packer4x8.sv
// xor_lane_packer4x8
// Serial-to-parallel packer in front of the 4-lane XOR fold stage.
// Bytes arrive one per input handshake and are gathered into groups of four
// lanes. A group closed early by I_last is zero-padded, which leaves the XOR
// fold result unchanged because zero is the XOR identity.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising CLK edge where valid and ready are both 1.
//   A producer holding valid=1 keeps its payload stable until the transfer.
//   ready may depend combinationally on the consumer side, never on valid.
//   Here I_ready = !O_valid | O_ready, so a downstream that drains the held
//   group in the same cycle lets a new byte in with no bubble.
//
// dbg_state / dbg_fill expose the FSM state and the fill count so that
// protocol checkers can bind to them without reaching into the hierarchy.

module xor_lane_packer4x8 #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             ASYNCRESET,
   input  logic [WIDTH-1:0] I,
   input  logic             I_valid,
   input  logic             I_last,
   output logic             I_ready,
   output logic [WIDTH-1:0] O0,
   output logic [WIDTH-1:0] O1,
   output logic [WIDTH-1:0] O2,
   output logic [WIDTH-1:0] O3,
   output logic [2:0]       O_count,
   output logic             O_last,
   output logic             O_valid,
   input  logic             O_ready,
   output logic             dbg_state,
   output logic [1:0]       dbg_fill
);

   // FILL: gathering bytes, O_valid=0. FULL: group presented, frozen until taken.
   typedef enum logic {
      S_FILL = 1'b0,
      S_FULL = 1'b1
   } state_t;

   state_t     state;
   logic [1:0] fill;     // next lane to be written while in FILL
   logic       accept;   // input byte taken at the coming edge
   logic       xfer;     // held group taken at the coming edge
   logic       close;    // the byte accepted in FILL completes a group

   // Ready is the only combinational output: open whenever the output slot
   // is empty or is being emptied this cycle.
   assign I_ready = !O_valid || O_ready;
   assign accept  = I_valid && I_ready;
   assign xfer    = O_valid && O_ready;
   assign close   = (fill == 2'd3) || I_last;

   assign dbg_state = state;
   assign dbg_fill  = fill;

   // Packer FSM: lane writes, group close, hand-off and zero-bubble restart.
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         state   <= S_FILL;
         fill    <= 2'd0;
         O0      <= '0;
         O1      <= '0;
         O2      <= '0;
         O3      <= '0;
         O_count <= 3'd0;
         O_last  <= 1'b0;
         O_valid <= 1'b0;
      end else begin
         case (state)
            S_FILL: begin
               if (accept) begin
                  // Lane 0 starts a group: lanes 1..3 are cleared here so
                  // any lane not reached before I_last reads as zero.
                  case (fill)
                     2'd0: begin
                        O0 <= I;
                        O1 <= '0;
                        O2 <= '0;
                        O3 <= '0;
                     end
                     2'd1:    O1 <= I;
                     2'd2:    O2 <= I;
                     default: O3 <= I;
                  endcase
                  if (close) begin
                     state   <= S_FULL;
                     O_valid <= 1'b1;
                     O_count <= {1'b0, fill} + 3'd1;
                     O_last  <= I_last;
                     fill    <= 2'd0;
                  end else begin
                     fill <= fill + 2'd1;
                  end
               end
            end

            S_FULL: begin
               // While O_valid & !O_ready nothing here changes; I_ready is 0
               // so no byte can be accepted either.
               if (xfer) begin
                  if (accept) begin
                     // Zero-bubble restart: the new byte opens the next group.
                     O0 <= I;
                     O1 <= '0;
                     O2 <= '0;
                     O3 <= '0;
                     if (I_last) begin
                        // Single-byte group: straight back to FULL.
                        state   <= S_FULL;
                        O_valid <= 1'b1;
                        O_count <= 3'd1;
                        O_last  <= 1'b1;
                        fill    <= 2'd0;
                     end else begin
                        state   <= S_FILL;
                        O_valid <= 1'b0;
                        O_count <= 3'd0;
                        O_last  <= 1'b0;
                        fill    <= 2'd1;
                     end
                  end else begin
                     state   <= S_FILL;
                     O_valid <= 1'b0;
                     O_count <= 3'd0;
                     O_last  <= 1'b0;
                     fill    <= 2'd0;
                  end
               end
            end

            default: begin
               state   <= S_FILL;
               O_valid <= 1'b0;
               fill    <= 2'd0;
            end
         endcase
      end
   end

endmodule
